// File: rtl/ascensor_pkg.sv
// Shared types and helpers for the elevator controller.
// With EMERGENCY_STOP_EN defined, the PARADA state is added to estado_t.
package ascensor_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SUBE   = 3'd1,
        BAJA   = 3'd2,
`ifdef EMERGENCY_STOP_EN
        PARADA = 3'd4,
`endif
        PUERTA = 3'd3
    } estado_t;

    localparam logic [1:0] EST_IDLE   = 2'b00;
    localparam logic [1:0] EST_SUBE   = 2'b01;
    localparam logic [1:0] EST_BAJA   = 2'b10;
    localparam logic [1:0] EST_PUERTA = 2'b11;

    function automatic int piso_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Helpers work on a 16-floor view; callers zero-extend narrower vectors.
    function automatic logic hay_arriba(input logic [15:0] pend, input logic [3:0] piso);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 16; i++)
            if (i > int'(piso) && pend[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic hay_abajo(input logic [15:0] pend, input logic [3:0] piso);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 16; i++)
            if (i < int'(piso) && pend[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] codifica(input estado_t e);
        case (e)
            SUBE:    return EST_SUBE;
            BAJA:    return EST_BAJA;
            PUERTA:  return EST_PUERTA;
            default: return EST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/control_ascensor_if.sv
// Call buttons / floor sensor in, motor / door / status out.
// With EMERGENCY_STOP_EN defined, the emergencia_i input is added.
interface control_ascensor_if #(parameter int N_PISOS = 8);
    import ascensor_pkg::*;
    localparam int PW = piso_w(N_PISOS);

    logic [N_PISOS-1:0] req_i;
    logic               sensor_piso;
`ifdef EMERGENCY_STOP_EN
    logic               emergencia_i;
`endif
    logic [PW-1:0]      piso_o;
    logic [1:0]         estado_o;
    logic               motor_sube;
    logic               motor_baja;
    logic               puerta_abierta;
    logic [N_PISOS-1:0] pendientes_o;

    modport slave (
        input  req_i, sensor_piso,
`ifdef EMERGENCY_STOP_EN
        input  emergencia_i,
`endif
        output piso_o, estado_o, motor_sube, motor_baja, puerta_abierta, pendientes_o
    );

    modport master (
        output req_i, sensor_piso,
`ifdef EMERGENCY_STOP_EN
        output emergencia_i,
`endif
        input  piso_o, estado_o, motor_sube, motor_baja, puerta_abierta, pendientes_o
    );
endinterface

// File: rtl/control_ascensor_temporizador_puerta.sv
// Door-open timer: loads DOOR_CYCLES-1 on carga, counts down while cuenta, fin at zero.
module temporizador_puerta #(
    parameter int DOOR_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic carga,
    input  logic cuenta,
    output logic fin
);
    localparam int CW = $clog2(DOOR_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carga)
            cnt_d = CW'(DOOR_CYCLES - 1);
        else if (cuenta && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign fin = (cnt_q == '0);
endmodule

// File: rtl/control_ascensor.sv
// Elevator car controller: latches calls and serves them with a SCAN policy.
// Optional EMERGENCY_STOP_EN adds an emergency stop (PARADA) state.
module control_ascensor
    import ascensor_pkg::*;
#(
    parameter int N_PISOS     = 8,
    parameter int DOOR_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    control_ascensor_if.slave bus
);
    localparam int PW = piso_w(N_PISOS);
    localparam logic [PW-1:0] PISO_TOP = PW'(N_PISOS - 1);

    estado_t            estado_q, estado_d;
    logic [PW-1:0]      piso_q, piso_d;
    logic [N_PISOS-1:0] pend_q, pend_d, want;
    logic               dir_q, dir_d;        // 1 = last move was up
    logic [1:0]         estado_o_q, estado_o_d;
    logic               motor_sube_q, motor_sube_d;
    logic               motor_baja_q, motor_baja_d;
    logic               puerta_q, puerta_d;
    logic               carga, fin, arriba, abajo;

    temporizador_puerta #(.DOOR_CYCLES(DOOR_CYCLES)) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .carga  (carga),
        .cuenta (estado_q == PUERTA),
        .fin    (fin)
    );

    always_comb begin
        want     = pend_q | bus.req_i;
        arriba   = hay_arriba(16'(want), 4'(piso_q));
        abajo    = hay_abajo(16'(want), 4'(piso_q));
        estado_d = estado_q;
        piso_d   = piso_q;
        dir_d    = dir_q;
        pend_d   = want;
        carga    = 1'b0;
`ifdef EMERGENCY_STOP_EN
        if (bus.emergencia_i) begin
            // Car may still coast; keep the floor count honest using the last direction.
            estado_d = PARADA;
            pend_d   = '0;
            if (bus.sensor_piso) begin
                if (dir_q && piso_q != PISO_TOP)   piso_d = piso_q + 1'b1;
                else if (!dir_q && piso_q != '0)   piso_d = piso_q - 1'b1;
            end
        end else
`endif
        case (estado_q)
            IDLE: begin
                if (want[piso_q]) begin
                    estado_d       = PUERTA;
                    pend_d[piso_q] = 1'b0;
                    carga          = 1'b1;
                end else if (arriba && (dir_q || !abajo)) begin
                    estado_d = SUBE;
                    dir_d    = 1'b1;
                end else if (abajo) begin
                    estado_d = BAJA;
                    dir_d    = 1'b0;
                end
            end
            SUBE: begin
                if (bus.sensor_piso && piso_q != PISO_TOP) begin
                    piso_d = piso_q + 1'b1;
                    if (want[piso_d]) begin
                        estado_d       = PUERTA;
                        pend_d[piso_d] = 1'b0;
                        carga          = 1'b1;
                    end
                end
            end
            BAJA: begin
                if (bus.sensor_piso && piso_q != '0) begin
                    piso_d = piso_q - 1'b1;
                    if (want[piso_d]) begin
                        estado_d       = PUERTA;
                        pend_d[piso_d] = 1'b0;
                        carga          = 1'b1;
                    end
                end
            end
            PUERTA: begin
                // A call at this floor keeps the door open instead of being latched.
                pend_d[piso_q] = 1'b0;
                if (bus.req_i[piso_q]) carga    = 1'b1;
                else if (fin)          estado_d = IDLE;
            end
`ifdef EMERGENCY_STOP_EN
            PARADA:  estado_d = IDLE;
`endif
            default: estado_d = IDLE;
        endcase
    end

    always_comb begin
        estado_o_d   = codifica(estado_d);
        motor_sube_d = (estado_d == SUBE);
        motor_baja_d = (estado_d == BAJA);
        puerta_d     = (estado_d == PUERTA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= IDLE;
            piso_q       <= '0;
            pend_q       <= '0;
            dir_q        <= 1'b1;
            estado_o_q   <= EST_IDLE;
            motor_sube_q <= 1'b0;
            motor_baja_q <= 1'b0;
            puerta_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            piso_q       <= piso_d;
            pend_q       <= pend_d;
            dir_q        <= dir_d;
            estado_o_q   <= estado_o_d;
            motor_sube_q <= motor_sube_d;
            motor_baja_q <= motor_baja_d;
            puerta_q     <= puerta_d;
        end
    end

    assign bus.piso_o         = piso_q;
    assign bus.estado_o       = estado_o_q;
    assign bus.motor_sube     = motor_sube_q;
    assign bus.motor_baja     = motor_baja_q;
    assign bus.puerta_abierta = puerta_q;
    assign bus.pendientes_o   = pend_q;
endmodule

// File: tb/tb_control_ascensor.sv
// Bench for control_ascensor: directed scenarios plus random traffic against a floor/mode model.
module tb_control_ascensor;
    localparam int N  = 8;
    localparam int DC = 16;

    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3, M_STOP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    control_ascensor_if #(.N_PISOS(N)) bus();
    control_ascensor #(.N_PISOS(N), .DOOR_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: floor number, what the car is doing, last direction, pending calls, door cycles left.
    int          fl;
    int          md;
    bit          up;
    bit [N-1:0]  pend;
    int          left;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        fl = 0; md = M_IDLE; up = 1'b1; pend = '0; left = 0;
    endtask

    function automatic bit any_between(input bit [N-1:0] w, input int lo, input int hi);
        bit r = 1'b0;
        for (int i = 0; i < N; i++)
            if (i >= lo && i <= hi && w[i]) r = 1'b1;
        return r;
    endfunction

    task automatic open_door();
        md = M_DOOR; pend[fl] = 1'b0; left = DC;
    endtask

    task automatic model_step(input bit [N-1:0] r, input bit s, input bit e);
        bit [N-1:0] want;
        bit above, below;
        want  = pend | r;
        above = any_between(want, fl + 1, N - 1);
        below = any_between(want, 0, fl - 1);
        if (e) begin
            md = M_STOP; pend = '0;
            if (s) begin
                if (up && fl < N - 1) fl++;
                else if (!up && fl > 0) fl--;
            end
            return;
        end
        case (md)
            M_STOP: begin md = M_IDLE; pend = want; end
            M_IDLE: begin
                pend = want;
                if (want[fl]) open_door();
                else if (above && (up || !below)) begin md = M_UP; up = 1'b1; end
                else if (below) begin md = M_DOWN; up = 1'b0; end
            end
            M_UP: begin
                pend = want;
                if (s && fl < N - 1) begin fl++; if (want[fl]) open_door(); end
            end
            M_DOWN: begin
                pend = want;
                if (s && fl > 0) begin fl--; if (want[fl]) open_door(); end
            end
            default: begin
                pend = want; pend[fl] = 1'b0;
                if (r[fl]) left = DC;
                else left--;
                if (left == 0) md = M_IDLE;
            end
        endcase
    endtask

    task automatic compare_all();
        int est;
        est = (md == M_UP) ? 1 : (md == M_DOWN) ? 2 : (md == M_DOOR) ? 3 : 0;
        chk("estado_o", int'(bus.estado_o), est);
        chk("piso_o", int'(bus.piso_o), fl);
        chk("pendientes_o", int'(bus.pendientes_o), int'(pend));
        chk("motor_sube", int'(bus.motor_sube), int'(md == M_UP));
        chk("motor_baja", int'(bus.motor_baja), int'(md == M_DOWN));
        chk("puerta_abierta", int'(bus.puerta_abierta), int'(md == M_DOOR));
    endtask

    // Apply inputs for one cycle, advance the model, check at the falling edge.
    task automatic tick(input logic [N-1:0] r, input logic s, input logic e);
        bus.req_i       = r;
        bus.sensor_piso = s;
`ifdef EMERGENCY_STOP_EN
        bus.emergencia_i = e;
`endif
        model_step(r, s, e);
        @(negedge clk);
        compare_all();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick('0, 1'b0, 1'b0);
    endtask

    task automatic sensor_pulses(input int n);
        repeat (n) begin
            tick('0, 1'b1, 1'b0);
            if (md != M_DOOR) idle(1);
        end
    endtask

    // Counts door-open cycles starting with the current one; bounded.
    task automatic wait_door(output int n);
        n = int'(bus.puerta_abierta);
        for (int g = 0; g < 200 && bus.puerta_abierta; g++) begin
            tick('0, 1'b0, 1'b0);
            if (bus.puerta_abierta) n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_i = '0;
        bus.sensor_piso = 1'b0;
`ifdef EMERGENCY_STOP_EN
        bus.emergencia_i = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] bitn(input int i);
        logic [N-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int n;
        int em_left;
        logic [N-1:0] r;

        // 1: single call to floor 3 from reset
        do_reset();
        chk("rst_estado", int'(bus.estado_o), 0);
        chk("rst_piso", int'(bus.piso_o), 0);
        chk("rst_pend", int'(bus.pendientes_o), 0);
        tick(bitn(3), 1'b0, 1'b0);
        chk("t1_sube", int'(bus.estado_o), 1);
        chk("t1_pend", int'(bus.pendientes_o), 8);
        idle(2);
        sensor_pulses(3);
        chk("t1_piso", int'(bus.piso_o), 3);
        chk("t1_puerta", int'(bus.estado_o), 3);
        wait_door(n);
        chk("t1_door_len", n, 16);
        chk("t1_idle", int'(bus.estado_o), 0);

        // 2: from 3 going up with calls at 5 and 1
        tick(bitn(5) | bitn(1), 1'b0, 1'b0);
        chk("t2_sube", int'(bus.estado_o), 1);
        sensor_pulses(2);
        chk("t2_piso5", int'(bus.piso_o), 5);
        chk("t2_pend5", int'(bus.pendientes_o), 2);
        wait_door(n);
        idle(1);
        chk("t2_baja", int'(bus.estado_o), 2);
        sensor_pulses(4);
        chk("t2_piso1", int'(bus.piso_o), 1);
        chk("t2_puerta1", int'(bus.estado_o), 3);
        chk("t2_pend0", int'(bus.pendientes_o), 0);
        wait_door(n);

        // 3: door extension at floor 2
        tick(bitn(2), 1'b0, 1'b0);
        sensor_pulses(1);
        wait_door(n);
        tick(bitn(2), 1'b0, 1'b0);
        chk("t3_door_next", int'(bus.estado_o), 3);
        n = 1;
        repeat (9) begin tick('0, 1'b0, 1'b0); n += int'(bus.puerta_abierta); end
        tick(bitn(2), 1'b0, 1'b0);
        n += int'(bus.puerta_abierta);
        for (int g = 0; g < 200 && bus.puerta_abierta; g++) begin
            tick('0, 1'b0, 1'b0);
            n += int'(bus.puerta_abierta);
        end
        chk("t3_door_len", n, 26);

        // 5: stray sensor pulses in IDLE and at the top floor
        tick('0, 1'b1, 1'b0);
        chk("t5_idle_piso", int'(bus.piso_o), 2);
        chk("t5_idle_est", int'(bus.estado_o), 0);
        tick(bitn(7), 1'b0, 1'b0);
        sensor_pulses(5);
        chk("t5_top", int'(bus.piso_o), 7);
        tick('0, 1'b1, 1'b0);
        chk("t5_door_piso", int'(bus.piso_o), 7);
        chk("t5_door_est", int'(bus.estado_o), 3);
        wait_door(n);
        tick('0, 1'b1, 1'b0);
        chk("t5_top_idle", int'(bus.piso_o), 7);

        // 4: asynchronous reset while moving up at floor 4
        do_reset();
        tick(bitn(6), 1'b0, 1'b0);
        sensor_pulses(4);
        chk("t4_piso4", int'(bus.piso_o), 4);
        chk("t4_motor", int'(bus.motor_sube), 1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_motor", int'(bus.motor_sube), 0);
        chk("t4_rst_piso", int'(bus.piso_o), 0);
        chk("t4_rst_pend", int'(bus.pendientes_o), 0);
        chk("t4_rst_est", int'(bus.estado_o), 0);
        model_reset();
        @(negedge clk);
        compare_all();
        #1;
        rst_n = 1'b1;

`ifdef EMERGENCY_STOP_EN
        // 6: emergency stop while moving down
        tick(bitn(3), 1'b0, 1'b0);
        sensor_pulses(3);
        wait_door(n);
        tick(bitn(0), 1'b0, 1'b0);
        chk("t6_baja", int'(bus.estado_o), 2);
        tick('0, 1'b0, 1'b1);
        chk("t6_est", int'(bus.estado_o), 0);
        chk("t6_motor", int'(bus.motor_baja), 0);
        chk("t6_pend", int'(bus.pendientes_o), 0);
        tick(bitn(5), 1'b1, 1'b1);
        chk("t6_track", int'(bus.piso_o), 2);
        chk("t6_noreq", int'(bus.pendientes_o), 0);
        tick('0, 1'b0, 1'b0);
        chk("t6_release", int'(bus.estado_o), 0);
        idle(1);
        chk("t6_stay", int'(bus.estado_o), 0);
`endif

        // Random traffic
        em_left = 0;
        for (int k = 0; k < 1500; k++) begin
            r = N'($urandom & $urandom & $urandom & $urandom);
`ifdef EMERGENCY_STOP_EN
            if (em_left == 0 && $urandom_range(0, 99) == 0) em_left = $urandom_range(1, 4);
`endif
            tick(r, ($urandom_range(0, 3) == 0), (em_left > 0));
            if (em_left > 0) em_left--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
